// File: rtl/uart_tx_arb_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arb_if
// Bundles the requester side (byte-valid/last/data with ack) and the uart_tx
// side (trmt/tx_data/tx_done) of the shared-transmitter arbiter.
//   req       : per-requester byte-valid, held until ack
//   req_last  : current byte is the last of its packet
//   req_data  : byte i in bits [8i+7:8i]
//   ack       : one-cycle capture pulse, one-hot
//   trmt      : one-cycle start pulse to uart_tx
//   tx_data   : byte presented to uart_tx
//   tx_done   : uart_tx completion pulse
// slave  : arbiter view.  master : requesters + transmitter view.
// -----------------------------------------------------------------------------
interface uart_tx_arb_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req;
   logic [NUM_REQ-1:0]   req_last;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   ack;
   logic                 trmt;
   logic [7:0]           tx_data;
   logic                 tx_done;

   modport slave (
      input  req, req_last, req_data, tx_done,
      output ack, trmt, tx_data
   );

   modport master (
      output req, req_last, req_data, tx_done,
      input  ack, trmt, tx_data
   );
endinterface

// File: rtl/uart_tx_arb.sv
// -----------------------------------------------------------------------------
// uart_tx_arb
// Round-robin arbiter/sequencer sharing one uart_tx among NUM_REQ requesters.
// A grant is held for a whole packet; if the owner goes quiet mid-packet for
// TIMEOUT cycles the grant is forcibly released and timeout_err latches.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus          : uart_tx_arb_if.slave (requester and uart_tx handshakes)
//   busy         : a packet grant is active
//   owner        : index of the current or last owner
//   timeout_err  : sticky forced-release flag, cleared only by reset
// -----------------------------------------------------------------------------
module uart_tx_arb #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic               clk,
   input  logic               rst_n,
   uart_tx_arb_if.slave       bus,
   output logic               busy,
   output logic [2:0]         owner,
   output logic               timeout_err
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT, HOLD} state_t;

   state_t            state_q, state_d;
   logic [2:0]        owner_q, owner_d;
   logic [2:0]        rr_ptr_q, rr_ptr_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              terr_q, terr_d;

   // Requester vectors padded to the 8-requester maximum so a 3-bit index
   // always selects exactly one bit/byte regardless of NUM_REQ.
   logic [7:0]  req_x;
   logic [7:0]  last_x;
   logic [63:0] data_x;
   logic [7:0]  ack_x;

   assign req_x  = 8'(bus.req);
   assign last_x = 8'(bus.req_last);
   assign data_x = 64'(bus.req_data);

   // Increment that wraps at NUM_REQ, so non-power-of-2 counts work.
   function automatic logic [2:0] next_idx(input logic [2:0] p);
      return (int'(p) >= NUM_REQ - 1) ? 3'd0 : p + 3'd1;
   endfunction

   // Round-robin search: first set req bit at or above rr_ptr, wrapping.
   logic [2:0] win;
   logic       win_vld;
   logic [3:0] cand;

   always_comb begin
      win     = 3'd0;
      win_vld = 1'b0;
      cand    = 4'd0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = 4'(rr_ptr_q) + 4'(i);
         if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
         if (!win_vld && req_x[cand[2:0]]) begin
            win     = cand[2:0];
            win_vld = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      rr_ptr_d  = rr_ptr_q;
      tx_data_d = tx_data_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      terr_d    = terr_q;
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               owner_d   = win;
               tx_data_d = data_x[{win, 3'b000} +: 8];
               last_d    = last_x[win];
               busy_d    = 1'b1;
               state_d   = LOAD;
            end
         end
         LOAD: state_d = WAIT;
         WAIT: begin
            if (bus.tx_done) begin
               if (last_q) begin
                  rr_ptr_d = next_idx(owner_q);
                  busy_d   = 1'b0;
                  state_d  = IDLE;
               end else if (req_x[owner_q]) begin
                  tx_data_d = data_x[{owner_q, 3'b000} +: 8];
                  last_d    = last_x[owner_q];
                  state_d   = LOAD;
               end else begin
                  cnt_d   = '0;
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            // Owner's next byte wins over an expiring timeout.
            if (req_x[owner_q]) begin
               tx_data_d = data_x[{owner_q, 3'b000} +: 8];
               last_d    = last_x[owner_q];
               state_d   = LOAD;
            end else if (cnt_q == CNT_MAX) begin
               terr_d   = 1'b1;
               rr_ptr_d = next_idx(owner_q);
               busy_d   = 1'b0;
               state_d  = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State/register boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         owner_q   <= 3'd0;
         rr_ptr_q  <= 3'd0;
         tx_data_q <= 8'h00;
         last_q    <= 1'b0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         terr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         rr_ptr_q  <= rr_ptr_d;
         tx_data_q <= tx_data_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         terr_q    <= terr_d;
      end
   end

   assign ack_x       = 8'd1 << owner_q;
   assign bus.trmt    = (state_q == LOAD);
   assign bus.ack     = (state_q == LOAD) ? ack_x[NUM_REQ-1:0] : '0;
   assign bus.tx_data = tx_data_q;
   assign busy        = busy_q;
   assign owner       = owner_q;
   assign timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
module tb_uart_tx_arb;
   localparam int NR = 4;
   localparam int TO = 16;

   typedef struct packed {
      logic [2:0] own;
      logic [7:0] d;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       busy, busy3, terr, terr3;
   logic [2:0] owner, owner3;

   uart_tx_arb_if #(.NUM_REQ(NR)) bus ();
   uart_tx_arb_if #(.NUM_REQ(3))  bus3 ();

   uart_tx_arb #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave),
      .busy(busy), .owner(owner), .timeout_err(terr)
   );

   uart_tx_arb #(.NUM_REQ(3), .TIMEOUT(TO)) dut3 (
      .clk(clk), .rst_n(rst_n), .bus(bus3.slave),
      .busy(busy3), .owner(owner3), .timeout_err(terr3)
   );

   initial forever #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [8:0] src_q [NR][$];   // {last, data} per requester
   exp_t       exp_q [$];
   logic [2:0] seen_own [$];
   int         m_ptr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.req = '0;  bus.req_last = '0;  bus.req_data = '0;  bus.tx_done = 1'b0;
      bus3.req = '0; bus3.req_last = '0; bus3.req_data = '0; bus3.tx_done = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      m_ptr = 0;
   endtask

   task automatic pulse_done();
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
   endtask

   task automatic present(input int r);
      if (src_q[r].size() == 0) begin
         bus.req[r] = 1'b0;
      end else begin
         bus.req[r]            = 1'b1;
         bus.req_last[r]       = src_q[r][0][8];
         bus.req_data[8*r +: 8] = src_q[r][0][7:0];
      end
   endtask

   // Packet-level reference: whole packets granted round-robin among
   // requesters that still have packets, starting after the previous owner.
   task automatic build_model();
      logic [8:0] cp [NR][$];
      logic [8:0] pkt;
      int         w, c;
      for (int r = 0; r < NR; r++) cp[r] = src_q[r];
      exp_q.delete();
      forever begin
         w = -1;
         for (int k = 0; k < NR; k++) begin
            c = (m_ptr + k) % NR;
            if (w < 0 && cp[c].size() > 0) w = c;
         end
         if (w < 0) break;
         do begin
            pkt = cp[w].pop_front();
            exp_q.push_back({3'(w), pkt[7:0]});
         end while (!pkt[8]);
         m_ptr = (w + 1) % NR;
      end
   endtask

   task automatic run_session(input bit gaps);
      int             gap [NR];
      bit             first [NR];
      int             dcnt, cyc;
      logic [8:0]     b;
      exp_t           e;
      logic [NR-1:0]  ack_s;
      logic           trmt_s;
      build_model();
      seen_own.delete();
      dcnt = 0;
      cyc  = 0;
      for (int r = 0; r < NR; r++) begin
         gap[r]   = 0;
         first[r] = 1'b1;
         present(r);
      end
      while (exp_q.size() > 0 || dcnt > 0 || busy) begin
         tick();
         cyc++;
         if (cyc > 3000) begin
            chk("session_left", exp_q.size(), 0);
            break;
         end
         ack_s  = bus.ack;
         trmt_s = bus.trmt;
         if (bus.tx_done) bus.tx_done = 1'b0;
         else if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) bus.tx_done = 1'b1;
         end
         if (trmt_s || ack_s != '0) begin
            if (exp_q.size() == 0) begin
               chk("extra_grant", 32'(ack_s), 0);
            end else begin
               e = exp_q.pop_front();
               chk("trmt", 32'(trmt_s), 1);
               chk("ack", 32'(ack_s), 32'(1) << e.own);
               chk("owner", 32'(owner), 32'(e.own));
               chk("tx_data", 32'(bus.tx_data), 32'(e.d));
               seen_own.push_back(owner);
               dcnt = $urandom_range(1, 5);
            end
         end
         for (int r = 0; r < NR; r++) begin
            if (ack_s[r]) begin
               if (src_q[r].size() > 0) begin
                  b        = src_q[r].pop_front();
                  first[r] = b[8];
               end
               if (src_q[r].size() == 0) bus.req[r] = 1'b0;
               else if (gaps && !first[r]) begin
                  bus.req[r] = 1'b0;
                  gap[r]     = $urandom_range(1, 4);
               end else present(r);
            end else if (gap[r] > 0) begin
               gap[r]--;
               if (gap[r] == 0) present(r);
            end
         end
      end
   endtask

   initial begin
      int         n, acks, np, len;
      logic [2:0] want [4];

      // Reset state
      do_reset();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_owner", 32'(owner), 0);
      chk("rst_trmt", 32'(bus.trmt), 0);
      chk("rst_ack", 32'(bus.ack), 0);
      chk("rst_txdata", 32'(bus.tx_data), 0);
      chk("rst_terr", 32'(terr), 0);

      // Single requester, single-byte packet
      bus.req[2] = 1'b1; bus.req_last[2] = 1'b1; bus.req_data[23:16] = 8'h67;
      chk("s_pre_trmt", 32'(bus.trmt), 0);
      tick();
      chk("s_trmt", 32'(bus.trmt), 1);
      chk("s_ack", 32'(bus.ack), 32'h4);
      chk("s_data", 32'(bus.tx_data), 32'h67);
      chk("s_busy", 32'(busy), 1);
      chk("s_owner", 32'(owner), 2);
      bus.req[2] = 1'b0;
      tick();
      chk("s_trmt_pulse", 32'(bus.trmt), 0);
      chk("s_ack_pulse", 32'(bus.ack), 0);
      tick(); tick();
      chk("s_hold_data", 32'(bus.tx_data), 32'h67);
      chk("s_busy_wait", 32'(busy), 1);
      pulse_done();
      chk("s_busy_fall", 32'(busy), 0);
      chk("s_owner_kept", 32'(owner), 2);
      bus.req = 4'b1111; bus.req_last = 4'b1111;
      tick();
      chk("s_rr_next", 32'(owner), 3);
      chk("s_rr_ack", 32'(bus.ack), 32'h8);
      bus.req = '0;
      tick();
      pulse_done();
      tick();

      // Contention: requesters 0,1,3 with 1-byte packets; 0 has two
      src_q[0] = '{9'h1A0, 9'h1A1};
      src_q[1] = '{9'h1B1};
      src_q[2] = {};
      src_q[3] = '{9'h1D3};
      run_session(1'b0);
      want = '{3'd0, 3'd1, 3'd3, 3'd0};
      chk("c_count", seen_own.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < seen_own.size()) chk("c_order", 32'(seen_own[i]), 32'(want[i]));

      // Packet lock: requester 1 sends three bytes while 0 waits
      src_q[0] = '{9'h142};
      src_q[1] = '{9'h0A5, 9'h05A, 9'h1FF};
      run_session(1'b0);
      want = '{3'd1, 3'd1, 3'd1, 3'd0};
      chk("l_count", seen_own.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < seen_own.size()) chk("l_order", 32'(seen_own[i]), 32'(want[i]));

      // Timeout release
      do_reset();
      bus.req[3] = 1'b1; bus.req_last[3] = 1'b0; bus.req_data[31:24] = 8'h3C;
      tick();
      chk("t_owner", 32'(owner), 3);
      chk("t_trmt", 32'(bus.trmt), 1);
      bus.req[3] = 1'b0;
      bus.req[0] = 1'b1; bus.req_last[0] = 1'b1; bus.req_data[7:0] = 8'h11;
      tick(); tick();
      pulse_done();
      n = 0; acks = 0;
      while (busy && n < 40) begin
         tick();
         n++;
         if (bus.ack[0]) acks++;
      end
      chk("t_cycles", n, 16);
      chk("t_hold_block", acks, 0);
      chk("t_err", 32'(terr), 1);
      tick();
      chk("t_next_owner", 32'(owner), 0);
      chk("t_next_ack", 32'(bus.ack), 1);
      chk("t_next_data", 32'(bus.tx_data), 32'h11);
      bus.req[0] = 1'b0;
      tick();
      pulse_done();
      tick();

      // Asynchronous reset while a byte is in flight
      bus.req[2] = 1'b1; bus.req_last[2] = 1'b0; bus.req_data[23:16] = 8'h9A;
      tick();
      chk("r_owner", 32'(owner), 2);
      bus.req[2] = 1'b0;
      tick();
      chk("r_busy", 32'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("r_busy_rst", 32'(busy), 0);
      chk("r_owner_rst", 32'(owner), 0);
      chk("r_data_rst", 32'(bus.tx_data), 0);
      chk("r_terr_rst", 32'(terr), 0);
      chk("r_trmt_rst", 32'(bus.trmt), 0);
      chk("r_ack_rst", 32'(bus.ack), 0);
      tick();
      rst_n = 1'b1;
      tick();
      bus.req[1] = 1'b1; bus.req_last[1] = 1'b1; bus.req_data[15:8] = 8'h77;
      tick();
      chk("r_new_owner", 32'(owner), 1);
      chk("r_new_ack", 32'(bus.ack), 32'h2);
      chk("r_new_data", 32'(bus.tx_data), 32'h77);
      bus.req[1] = 1'b0;
      tick();
      pulse_done();
      tick();

      // Three-requester wrap
      bus3.req = 3'b100; bus3.req_last = 3'b111; bus3.req_data = 24'h33_22_11;
      tick();
      chk("w_owner2", 32'(owner3), 2);
      chk("w_trmt", 32'(bus3.trmt), 1);
      bus3.req = '0;
      tick();
      bus3.tx_done = 1'b1;
      tick();
      bus3.tx_done = 1'b0;
      bus3.req = 3'b111;
      tick();
      chk("w_wrap_owner", 32'(owner3), 0);
      chk("w_wrap_ack", 32'(bus3.ack), 1);
      chk("w_wrap_data", 32'(bus3.tx_data), 32'h11);
      bus3.req = '0;

      // Randomized packet traffic with intra-packet gaps
      do_reset();
      for (int round = 0; round < 12; round++) begin
         for (int r = 0; r < NR; r++) begin
            src_q[r].delete();
            np = $urandom_range(0, 3);
            for (int p = 0; p < np; p++) begin
               len = $urandom_range(1, 4);
               for (int k = 0; k < len; k++)
                  src_q[r].push_back({(k == len - 1), 8'($urandom)});
            end
         end
         run_session(1'b1);
         chk("rand_terr", 32'(terr), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
